ram_sp_ctrl: RTL and testbench
==============================

# ram_sp_ctrl

Parametrised single-port synchronous RAM controller for the FPGA top level. It replaces the fixed 8x256 wrapper with a configurable-width, configurable-depth memory behind a request/ready handshake. It adds a registered read path with a valid strobe, and a hardware clear sequencer that zero-fills the array after reset or on command. Optional per-word parity detects corrupted reads.

## Interface
- DATA_W, default 8: data word width, 1..64.
- ADDR_W, default 8: address width.
- DEPTH, default 256: number of words; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W.
- CLEAR_VAL, default 0: word value written by the clear sequencer (DATA_W bits).

Ports:
- clock_50mhz, in, 1: single system clock; all logic is rising-edge.
- reset_n, in, 1: asynchronous, active-low reset.
- pin_req, in, 1: operation request, qualified by pin_ready.
- pin_write, in, 1: operation select; 0 = read, 1 = write.
- pin_addr, in, ADDR_W: word address.
- pin_dataIn, in, DATA_W: write data.
- pin_clear, in, 1: one-cycle request to clear the whole array.
- pin_par_flip, in, 1: test-only; stores inverted parity on a write. Ignored without the parity macro.
- pin_ready, out, 1: controller accepts a request this cycle.
- pin_busy, out, 1: clear sequence in progress.
- pin_valid, out, 1: one-cycle strobe; pin_dataOut holds new read data.
- pin_dataOut, out, DATA_W: read data; holds its value between reads.
- pin_err, out, 1: parity error flag, qualified by pin_valid.

## Operation
- FSM states: S_CLEAR and S_READY. The reset state is S_CLEAR with clr_addr = 0.
- S_CLEAR:
  - Writes CLEAR_VAL to clr_addr each cycle and increments clr_addr.
  - After writing address DEPTH-1, goes to S_READY on the same edge.
  - pin_req is ignored in this state.
- S_READY:
  - pin_ready = (state == S_READY) && !pin_clear; this is combinational.
  - Accept condition: pin_req && pin_ready.
  - pin_clear high in S_READY moves to S_CLEAR on the next edge with clr_addr = 0. pin_clear wins over a simultaneous pin_req; that request is not accepted.
  - pin_clear is ignored while in S_CLEAR; the sequence does not restart.
- Accepted write: the array location is updated on the accepting edge.
- Accepted read: the array is read on the accepting edge. pin_dataOut and pin_valid are registered one edge later.
- Back-to-back operations, one per cycle, run at full rate. A read accepted the cycle after a write to the same address returns the new data.
- Out-of-range address (pin_addr ≥ DEPTH):
  - The request is still accepted.
  - A write is dropped.
  - A read returns CLEAR_VAL with pin_valid = 1 and pin_err = 0.
- Reset asserted at any time, including mid-clear, forces S_CLEAR with clr_addr = 0. The clear restarts from the beginning after release. Array contents are not reset directly.

## Timing
- Reset values:
  - pin_ready = 0, pin_busy = 1, pin_valid = 0.
  - pin_dataOut = 0, pin_err = 0.
- Clear duration is exactly DEPTH cycles from the first clock edge after reset_n rises. With DEPTH = 256, pin_ready rises after the 256th edge.
- pin_busy = (state == S_CLEAR), derived from the registered state.
- Read latency is 1 cycle: a request accepted at edge N gives pin_valid = 1 after edge N+1 for exactly one cycle, unless another read was accepted at N+1.
- Writes produce no pin_valid.

## Configuration
- Macro RAM_SP_CTRL_PARITY_EN.
- When defined:
  - The array is DATA_W+1 bits wide and stores even parity of the data.
  - pin_par_flip on a write stores inverted parity.
  - The clear sequencer writes the correct parity for CLEAR_VAL.
  - On a read, pin_err = 1 with pin_valid if the recomputed parity mismatches the stored parity.
- When undefined:
  - The array is DATA_W bits wide.
  - pin_err is tied to 0 and pin_par_flip is unused.

## Structure
- Package ram_sp_ctrl_pkg holds:
  - the state enum (S_CLEAR, S_READY);
  - the default parameter constants;
  - a parity function on DATA_W data.
- Sub-module ram_sp_core is the behavioural array. It has one write port and a registered read port, and is inferable as block RAM. The controller holds the FSM, the address/data mux and the output registers.

## Test plan
- Reset release with DEPTH = 256 → pin_busy = 1 and pin_ready = 0 for 256 cycles, then pin_ready = 1. A read of address 0x7F returns 0x00 with pin_valid one cycle after acceptance.
- Write 0xA5 to 0x10, then read 0x10 on the next cycle → pin_dataOut = 0xA5, pin_valid pulses 1 cycle after the read is accepted.
- Alternating write/read every cycle across addresses 0..15 with data = addr^0x3C → every read returns the matching value; no stalls.
- pin_clear together with pin_req on a write to 0x20 → write not accepted, 256-cycle clear runs, then read 0x20 returns CLEAR_VAL. Repeat with reset_n pulsed at clear cycle 100 → clear restarts, full 256 cycles.
- DEPTH = 200, ADDR_W = 8:
  - Write 0x55 to 0xF0 → the write is dropped.
  - Read 0xF0 → returns CLEAR_VAL with pin_valid = 1.
- With RAM_SP_CTRL_PARITY_EN: write 0x0F with pin_par_flip = 1 → read gives pin_err = 1. Rewrite 0x0F normally → pin_err = 0.

Source files
------------

// File: rtl/ram_sp_ctrl_pkg.sv
// Shared types and constants for the single-port RAM controller.
// Parity storage is enabled by defining RAM_SP_CTRL_PARITY_EN.
package ram_sp_ctrl_pkg;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;

  // Even parity; callers zero-extend narrower words, which leaves the result unchanged.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Behavioural single-port array: one write port, registered read port.
// Written in the canonical block-RAM inference template.
module ram_sp_core
  import ram_sp_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map them to block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// Single-port RAM controller: clear sequencer, req/ready handshake, registered read path.
// Define RAM_SP_CTRL_PARITY_EN to store and check even parity per word.
module ram_sp_ctrl
  import ram_sp_ctrl_pkg::*;
#(
  parameter int unsigned      DATA_W    = DEF_DATA_W,
  parameter int unsigned      ADDR_W    = DEF_ADDR_W,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock_50mhz,
  input  logic              reset_n,
  input  logic              pin_req,
  input  logic              pin_write,
  input  logic [ADDR_W-1:0] pin_addr,
  input  logic [DATA_W-1:0] pin_dataIn,
  input  logic              pin_clear,
  input  logic              pin_par_flip,
  output logic              pin_ready,
  output logic              pin_busy,
  output logic              pin_valid,
  output logic [DATA_W-1:0] pin_dataOut,
  output logic              pin_err
);

`ifdef RAM_SP_CTRL_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_oor_q, rd_oor_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              in_range;
  logic              accept;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;
  logic [MEM_W-1:0]  clear_word, wr_word;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  assign rd_data = mem_rdata[DATA_W-1:0];

`ifdef RAM_SP_CTRL_PARITY_EN
  assign clear_word = {even_parity(64'(CLEAR_VAL)), CLEAR_VAL};
  assign wr_word    = {even_parity(64'(pin_dataIn)) ^ pin_par_flip, pin_dataIn};
  assign rd_err     = even_parity(64'(rd_data)) ^ mem_rdata[DATA_W];
`else
  logic unused_par_flip;
  assign unused_par_flip = pin_par_flip;
  assign clear_word      = CLEAR_VAL;
  assign wr_word         = pin_dataIn;
  assign rd_err          = 1'b0;
`endif

  assign in_range  = {1'b0, pin_addr} < DEPTH_L;
  assign pin_ready = (state_q == S_READY) && !pin_clear;
  assign accept    = pin_req && pin_ready;
  assign pin_busy  = (state_q == S_CLEAR);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = pin_addr;
    mem_wdata  = wr_word;
    rd_pend_d  = 1'b0;
    rd_oor_d   = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr_q;
        mem_wdata = clear_word;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_READY;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_READY: begin
        if (pin_clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (accept) begin
          // Out-of-range accesses are accepted but never touch the array.
          mem_we    = pin_write && in_range;
          mem_re    = !pin_write && in_range;
          rd_pend_d = !pin_write;
          rd_oor_d  = !in_range;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_oor_q   <= rd_oor_d;
      valid_q    <= rd_pend_q;
      if (rd_pend_q) begin
        data_q <= rd_oor_q ? CLEAR_VAL : rd_data;
        err_q  <= !rd_oor_q && rd_err;
      end
    end
  end

  ram_sp_core #(
    .WIDTH (MEM_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clk  (clock_50mhz),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign pin_valid   = valid_q;
  assign pin_dataOut = data_q;
  assign pin_err     = err_q;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Directed bench for ram_sp_ctrl: scoreboard of expected reads on a DEPTH=256 instance,
// plus a DEPTH=200 instance sharing the same stimulus for out-of-range behaviour.
module tb_ram_sp_ctrl;

`ifdef RAM_SP_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       req, write, clear, par_flip;
  logic [7:0] addr, din;
  logic       ready, busy, valid, err;
  logic [7:0] dout;
  logic       ready2, busy2, valid2, err2;
  logic [7:0] dout2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mdl     [256];
  logic       mdl_err [256];

  ram_sp_ctrl u_dut (
    .clock_50mhz (clk),
    .reset_n     (reset_n),
    .pin_req     (req),
    .pin_write   (write),
    .pin_addr    (addr),
    .pin_dataIn  (din),
    .pin_clear   (clear),
    .pin_par_flip(par_flip),
    .pin_ready   (ready),
    .pin_busy    (busy),
    .pin_valid   (valid),
    .pin_dataOut (dout),
    .pin_err     (err)
  );

  ram_sp_ctrl #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .DEPTH    (200),
    .CLEAR_VAL(8'hC3)
  ) u_dut200 (
    .clock_50mhz (clk),
    .reset_n     (reset_n),
    .pin_req     (req),
    .pin_write   (write),
    .pin_addr    (addr),
    .pin_dataIn  (din),
    .pin_clear   (clear),
    .pin_par_flip(par_flip),
    .pin_ready   (ready2),
    .pin_busy    (busy2),
    .pin_valid   (valid2),
    .pin_dataOut (dout2),
    .pin_err     (err2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Read results are due exactly one edge after the accepting edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rd_valid", 64'(valid), 64'(1));
      chk("rd_data", 64'(dout), 64'(e.data));
      chk("rd_err", 64'(err), 64'(e.err));
    end else begin
      chk("idle_valid", 64'(valid), 64'(0));
    end
  end

  task automatic op(input logic w, input logic [7:0] a, input logic [7:0] d, input logic f);
    @(negedge clk);
    req = 1'b1; write = w; addr = a; din = d; par_flip = f;
    #1;
    chk("req_ready", 64'(ready), 64'(1));
    if (w) begin
      mdl[a]     = d;
      mdl_err[a] = PAR & f;
    end else begin
      sb.push_back('{cyc + 2, mdl[a], mdl_err[a]});
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; write = 1'b0; clear = 1'b0; par_flip = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      mdl[i]     = 8'h00;
      mdl_err[i] = 1'b0;
    end
  endtask

  // Busy for n-1 sampled edges, ready after the n-th.
  task automatic wait_clear(input int n);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
      chk("clr_busy", 64'(busy), 64'(1));
      chk("clr_not_ready", 64'(ready), 64'(0));
    end
    @(posedge clk); #1;
    chk("clr_done_ready", 64'(ready), 64'(1));
    chk("clr_done_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; write = 1'b0; clear = 1'b0; par_flip = 1'b0;
    addr = 8'h00; din = 8'h00;
    model_clear();
    #15;
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy2", 64'(busy2), 64'(1));

    @(negedge clk) reset_n = 1'b1;
    wait_clear(256);
    chk("dut200_ready", 64'(ready2), 64'(1));

    op(1'b0, 8'h7F, 8'h00, 1'b0);
    op(1'b1, 8'h10, 8'hA5, 1'b0);
    op(1'b0, 8'h10, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      op(1'b1, 8'(i), 8'(i) ^ 8'h3C, 1'b0);
      op(1'b0, 8'(i), 8'h00, 1'b0);
    end

    // Parity: flipped write reads back with err only when parity is built in.
    op(1'b1, 8'h30, 8'h0F, 1'b1);
    op(1'b0, 8'h30, 8'h00, 1'b0);
    op(1'b1, 8'h30, 8'h0F, 1'b0);
    op(1'b0, 8'h30, 8'h00, 1'b0);

    // Clear wins over a simultaneous write.
    op(1'b1, 8'h20, 8'h77, 1'b0);
    op(1'b0, 8'h20, 8'h00, 1'b0);
    @(negedge clk);
    clear = 1'b1; req = 1'b1; write = 1'b1; addr = 8'h20; din = 8'h99;
    #1;
    chk("clear_blocks_ready", 64'(ready), 64'(0));
    @(posedge clk); #1;
    chk("clear_enter_busy", 64'(busy), 64'(1));
    idle();
    model_clear();
    wait_clear(256);
    op(1'b0, 8'h20, 8'h00, 1'b0);
    op(1'b0, 8'h10, 8'h00, 1'b0);

    // Reset pulsed 100 cycles into a clear restarts the full sequence.
    @(negedge clk);
    req = 1'b0; clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    repeat (100) @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("midclr_rst_busy", 64'(busy), 64'(1));
    chk("midclr_rst_ready", 64'(ready), 64'(0));
    chk("midclr_rst_valid", 64'(valid), 64'(0));
    @(negedge clk) reset_n = 1'b1;
    wait_clear(256);
    op(1'b0, 8'h20, 8'h00, 1'b0);

    // DEPTH=200 instance: out-of-range write dropped, read returns CLEAR_VAL.
    op(1'b1, 8'hF0, 8'h55, 1'b0);
    op(1'b0, 8'hF0, 8'h00, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("oor_valid", 64'(valid2), 64'(1));
    chk("oor_data", 64'(dout2), 64'(8'hC3));
    chk("oor_err", 64'(err2), 64'(0));
    op(1'b0, 8'h05, 8'h00, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("d200_clear_val", 64'(dout2), 64'(8'hC3));
    op(1'b1, 8'hC7, 8'h5A, 1'b0);
    op(1'b0, 8'hC7, 8'h00, 1'b0);
    idle();
    @(posedge clk); #1;
    chk("d200_last_valid", 64'(valid2), 64'(1));
    chk("d200_last_data", 64'(dout2), 64'(8'h5A));

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
